uart_cmd_parser: RTL and testbench

//  Sequences the UART receive stream into calculator commands for the CPU; sits between uart_rx and the SOC MMIO bus.

---
 rtl/uart_cmd_parser_pkg.sv | 59 +++++
 rtl/uart_cmd_echo.sv | 31 +++
 rtl/uart_cmd_parser.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART calculator command parser.
//  - opcode and error code values driven on cmd_op / err_code
//  - ASCII constants for the frame grammar "OP SP D D [SP D D]"
//  - FSM state encoding
//  - helpers: opcode decode and 2-digit decimal to binary conversion
package uart_cmd_parser_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;   // '+'
    localparam logic [2:0] OP_SUB  = 3'd1;   // '-'
    localparam logic [2:0] OP_MUL  = 3'd2;   // '*'
    localparam logic [2:0] OP_DIV  = 3'd3;   // '/'
    localparam logic [2:0] OP_SQRT = 3'd4;   // 'S', unary

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SYNTAX  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,
        S_SP1 = 3'd1,
        S_A1  = 3'd2,
        S_A0  = 3'd3,
        S_SP2 = 3'd4,
        S_B1  = 3'd5,
        S_B0  = 3'd6
    } state_e;

    // {hit, opcode}; hit=0 for any byte that is not an operator
    function automatic logic [3:0] op_decode(input logic [7:0] c);
        case (c)
            ASC_PLUS:  return {1'b1, OP_ADD};
            ASC_MINUS: return {1'b1, OP_SUB};
            ASC_STAR:  return {1'b1, OP_MUL};
            ASC_SLASH: return {1'b1, OP_DIV};
            ASC_S:     return {1'b1, OP_SQRT};
            default:   return 4'b0;
        endcase
    endfunction

    // hi*10 + lo without a multiplier; max 99 fits in 7 bits
    function automatic logic [6:0] dec2(input logic [3:0] hi, input logic [3:0] lo);
        logic [6:0] h;
        h = {3'b0, hi};
        return (h << 3) + (h << 1) + {3'b0, lo};
    endfunction

endpackage

// File: rtl/uart_cmd_echo.sv
// One-deep valid/ready byte buffer used to echo received bytes to uart_tx.
// A byte is captured when the buffer is empty or draining in the same cycle;
// otherwise it is dropped (no backpressure toward the receiver).
// Ports:
//  clk, reset           clock, synchronous active-high reset
//  in_valid, in_data    byte strobe from the receiver
//  out_valid, out_data  buffered byte toward uart_tx
//  out_ready            uart_tx accepts the buffered byte
module uart_cmd_echo (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (in_valid && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART calculator command parser.
// Turns the uart_rx byte stream into commands "OP SP D D [SP D D]" for the
// CPU, holding one command until the CPU accepts it. Flags syntax errors,
// inter-byte timeouts inside a frame and command overrun.
// Optional feature: define CMD_ECHO_EN to echo every received byte through
// a one-deep buffer on tx_valid/tx_data/tx_ready.
// Ports:
//  clk, reset               clock, synchronous active-high reset
//  rx_valid, rx_data        one-cycle byte strobe from uart_rx
//  cmd_valid, cmd_ready     held command handshake with the CPU
//  cmd_op, cmd_a, cmd_b     opcode and operands (cmd_b=0 for SQRT)
//  err_valid, err_code      one-cycle error pulse, last error code held
//  tx_valid, tx_data,       echo stream (CMD_ECHO_EN only)
//  tx_ready
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [6:0] cmd_a,
    output logic [6:0] cmd_b,
    output logic       err_valid,
    output logic [1:0] err_code
`ifdef CMD_ECHO_EN
    ,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e        state, state_nxt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    op_q;
    logic [3:0]    hi_q;
    logic [6:0]    a_q;

    logic [3:0]    op_dec;
    logic          is_digit;
    logic [3:0]    digit;
    logic          timeout_hit;
    logic          commit;
    logic          load;
    logic          err;
    logic [1:0]    err_code_nxt;
    logic [6:0]    new_a;
    logic [6:0]    new_b;

    assign op_dec   = op_decode(rx_data);
    assign is_digit = (rx_data >= ASC_0) && (rx_data <= ASC_9);
    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
    assign digit    = rx_data[3:0];

    // A byte arriving in the expiry cycle wins over the timeout
    assign timeout_hit = (state != S_OP) && !rx_valid &&
                         (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign new_a = (state == S_A0) ? dec2(hi_q, digit) : a_q;
    assign new_b = (state == S_B0) ? dec2(hi_q, digit) : 7'd0;

    always_ff @(posedge clk) begin
        if (reset) state <= S_OP;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        commit       = 1'b0;
        err          = 1'b0;
        err_code_nxt = ERR_NONE;
        if (timeout_hit) begin
            err          = 1'b1;
            err_code_nxt = ERR_TIMEOUT;
            state_nxt    = S_OP;
        end else if (rx_valid) begin
            err          = 1'b1;   // cleared below by every accepted byte
            err_code_nxt = ERR_SYNTAX;
            state_nxt    = S_OP;
            case (state)
                S_OP: begin
                    if (op_dec[3]) begin
                        err = 1'b0; state_nxt = S_SP1;
                    end else if (rx_data == ASC_SP || rx_data == ASC_CR || rx_data == ASC_LF) begin
                        err = 1'b0; state_nxt = S_OP;
                    end
                end
                S_SP1: if (rx_data == ASC_SP) begin err = 1'b0; state_nxt = S_A1; end
                S_A1:  if (is_digit)          begin err = 1'b0; state_nxt = S_A0; end
                S_A0: begin
                    if (is_digit) begin
                        err = 1'b0;
                        if (op_q == OP_SQRT) begin
                            commit = 1'b1; state_nxt = S_OP;
                        end else begin
                            state_nxt = S_SP2;
                        end
                    end
                end
                S_SP2: if (rx_data == ASC_SP) begin err = 1'b0; state_nxt = S_B1; end
                S_B1:  if (is_digit)          begin err = 1'b0; state_nxt = S_B0; end
                S_B0:  if (is_digit)          begin err = 1'b0; commit = 1'b1; state_nxt = S_OP; end
                default: ;
            endcase
            if (!err) err_code_nxt = ERR_NONE;
            // A held command that is not being accepted this cycle blocks the new one
            if (commit && cmd_valid && !cmd_ready) begin
                err          = 1'b1;
                err_code_nxt = ERR_OVERRUN;
            end
        end
    end

    assign load = commit && !(cmd_valid && !cmd_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_ADD;
            hi_q      <= 4'd0;
            a_q       <= 7'd0;
            cmd_valid <= 1'b0;
            cmd_op    <= 3'd0;
            cmd_a     <= 7'd0;
            cmd_b     <= 7'd0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            to_cnt    <= '0;
        end else begin
            // Frame scratch registers; stale contents after an error are never used
            if (rx_valid) begin
                if (state == S_OP && op_dec[3])          op_q <= op_dec[2:0];
                if (state == S_A1 || state == S_B1)      hi_q <= digit;
                if (state == S_A0)                       a_q  <= new_a;
            end

            if (load) begin
                cmd_valid <= 1'b1;
                cmd_op    <= op_q;
                cmd_a     <= new_a;
                cmd_b     <= new_b;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            err_valid <= err;
            if (err) err_code <= err_code_nxt;

            if (rx_valid || state == S_OP || timeout_hit) to_cnt <= '0;
            else                                          to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef CMD_ECHO_EN
    uart_cmd_echo u_echo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rx_valid),
        .in_data   (rx_data),
        .out_valid (tx_valid),
        .out_data  (tx_data),
        .out_ready (tx_ready)
    );
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: table of frames plus hand-written sequences
// for timeout, overrun, same-cycle handshake, reset and (CMD_ECHO_EN) echo.
// Expected commands, errors and echo bytes are queued when stimulus is sent
// and checked by negedge monitors as the DUT produces them.
module tb_uart_cmd_parser;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [6:0] cmd_a;
    logic [6:0] cmd_b;
    logic       err_valid;
    logic [1:0] err_code;
`ifdef CMD_ECHO_EN
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_check;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] op;
        logic [6:0] a;
        logic [6:0] b;
    } cmd_t;

    typedef struct {
        logic [95:0] frame;
        int          len;
        logic        has_cmd;
        logic [2:0]  op;
        logic [6:0]  a;
        logic [6:0]  b;
        logic        has_err;
        logic [1:0]  code;
    } vec_t;

    cmd_t       exp_cmd[$];
    logic [1:0] exp_err[$];
    logic [7:0] exp_tx[$];
    vec_t       vt[10];

    uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .err_valid (err_valid),
        .err_code  (err_code)
`ifdef CMD_ECHO_EN
        ,
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", 1, 0);
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    check("cmd_op", int'(cmd_op), int'(e.op));
                    check("cmd_a",  int'(cmd_a),  int'(e.a));
                    check("cmd_b",  int'(cmd_b),  int'(e.b));
                end
            end
            if (err_valid) begin
                if (exp_err.size() == 0) begin
                    check("unexpected_err", int'(err_code), 0);
                end else begin
                    logic [1:0] c;
                    c = exp_err.pop_front();
                    check("err_code", int'(err_code), int'(c));
                end
            end
`ifdef CMD_ECHO_EN
            if (tx_check && tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx", int'(tx_data), 0);
                end else begin
                    logic [7:0] d;
                    d = exp_tx.pop_front();
                    check("tx_data", int'(tx_data), int'(d));
                end
            end
`endif
        end
    end

    // Called at posedge+1; byte is sampled on the next posedge, then `gap` idle cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [95:0] f, input int len, input int gap);
        for (int i = 0; i < len; i++) send_byte(f[8*(len-1-i) +: 8], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [6:0] a, input logic [6:0] b);
        cmd_t c;
        c.op = op; c.a = a; c.b = b;
        exp_cmd.push_back(c);
    endtask

    task automatic drained(input string name);
        check({name, "_cmd_drained"}, exp_cmd.size(), 0);
        check({name, "_err_drained"}, exp_err.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{96'("* 10 05"),             7,  1'b1, 3'd2, 7'd10, 7'd5,  1'b0, 2'd0};
        vt[1] = '{96'("/ 81 09"),             7,  1'b1, 3'd3, 7'd81, 7'd9,  1'b0, 2'd0};
        vt[2] = '{96'("S 64"),                4,  1'b1, 3'd4, 7'd64, 7'd0,  1'b0, 2'd0};
        vt[3] = '{96'("*X"),                  2,  1'b0, 3'd0, 7'd0,  7'd0,  1'b1, 2'd1};
        vt[4] = '{96'("* 1A"),                4,  1'b0, 3'd0, 7'd0,  7'd0,  1'b1, 2'd1};
        vt[5] = '{96'("+ 99 00"),             7,  1'b1, 3'd0, 7'd99, 7'd0,  1'b0, 2'd0};
        vt[6] = '{96'(" \015\012- 00 99"),    10, 1'b1, 3'd1, 7'd0,  7'd99, 1'b0, 2'd0};
        vt[7] = '{96'("Q"),                   1,  1'b0, 3'd0, 7'd0,  7'd0,  1'b1, 2'd1};
        vt[8] = '{96'("S 6x"),                4,  1'b0, 3'd0, 7'd0,  7'd0,  1'b1, 2'd1};
        vt[9] = '{96'("- 42 7 "),             7,  1'b0, 3'd0, 7'd0,  7'd0,  1'b1, 2'd1};

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
`ifdef CMD_ECHO_EN
        tx_ready  = 1'b1;
        tx_check  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_err_code",  int'(err_code),  0);
        check("rst_cmd_op",    int'(cmd_op),    0);
        check("rst_cmd_a",     int'(cmd_a),     0);
        check("rst_cmd_b",     int'(cmd_b),     0);
`ifdef CMD_ECHO_EN
        check("rst_tx_valid",  int'(tx_valid),  0);
`endif

        // Table of frames, CPU always ready
        for (int i = 0; i < 10; i++) begin
            if (vt[i].has_cmd) push_cmd(vt[i].op, vt[i].a, vt[i].b);
            if (vt[i].has_err) exp_err.push_back(vt[i].code);
            send_frame(vt[i].frame, vt[i].len, 0);
            idle(4);
            drained($sformatf("vec%0d", i));
            check($sformatf("vec%0d_cmd_valid_low", i), int'(cmd_valid), 0);
        end

        // Inter-byte timeout: no error one cycle early, error after T idle cycles
        exp_err.push_back(2'd2);
        send_frame(96'("+ 1"), 3, 0);
        idle(T - 2);
        check("timeout_not_early", exp_err.size(), 1);
        idle(3);
        check("timeout_fired", exp_err.size(), 0);
        check("timeout_code_held", int'(err_code), 2);
        push_cmd(3'd1, 7'd20, 7'd7);
        send_frame(96'("- 20 07"), 7, 0);
        idle(4);
        drained("after_timeout");

        // Bytes arriving exactly in the expiry cycle keep the frame alive
        push_cmd(3'd0, 7'd12, 7'd34);
        send_frame(96'("+ 12 34"), 7, T - 1);
        idle(4);
        drained("expiry_cycle");

        // Overrun: held command survives a second frame
        cmd_ready = 1'b0;
        push_cmd(3'd0, 7'd1, 7'd2);
        send_frame(96'("+ 01 02"), 7, 0);
        idle(2);
        check("ovr_first_held", int'(cmd_valid), 1);
        exp_err.push_back(2'd3);
        send_frame(96'("- 03 04"), 7, 0);
        idle(3);
        check("ovr_err_seen", exp_err.size(), 0);
        check("ovr_err_code", int'(err_code), 3);
        check("ovr_valid",    int'(cmd_valid), 1);
        check("ovr_op",       int'(cmd_op), 0);
        check("ovr_a",        int'(cmd_a),  1);
        check("ovr_b",        int'(cmd_b),  2);
        cmd_ready = 1'b1;
        idle(3);
        drained("overrun");
        check("ovr_valid_low", int'(cmd_valid), 0);

        // Commit in the same cycle as the handshake: both commands, no error
        cmd_ready = 1'b0;
        push_cmd(3'd2, 7'd11, 7'd22);
        send_frame(96'("* 11 22"), 7, 0);
        idle(2);
        push_cmd(3'd3, 7'd33, 7'd44);
        send_frame(96'("/ 33 4"), 6, 0);
        cmd_ready = 1'b1;
        send_byte(8'h34, 0);
        idle(4);
        drained("same_cycle");
        check("same_cycle_valid_low", int'(cmd_valid), 0);

        // Reset with a pending command and a partial frame clears everything
        cmd_ready = 1'b0;
        send_frame(96'("+ 05 06"), 7, 0);
        send_frame(96'("- 0"), 3, 0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("midrst_cmd_valid", int'(cmd_valid), 0);
        check("midrst_cmd_a",     int'(cmd_a),     0);
        check("midrst_err_code",  int'(err_code),  0);
        cmd_ready = 1'b1;
        push_cmd(3'd4, 7'd9, 7'd0);
        send_frame(96'("S 09"), 4, 0);
        idle(4);
        drained("after_reset");

`ifdef CMD_ECHO_EN
        // Echo with a ready transmitter reproduces the whole stream
        idle(2);
        tx_check = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic [55:0] s;
            s = "* 10 05";
            exp_tx.push_back(s[8*(6-i) +: 8]);
        end
        push_cmd(3'd2, 7'd10, 7'd5);
        send_frame(96'("* 10 05"), 7, 0);
        idle(4);
        check("echo_all_drained", exp_tx.size(), 0);
        drained("echo_ready");

        // Stalled transmitter: only the first byte is kept, parsing unaffected
        tx_ready = 1'b0;
        exp_tx.push_back(8'h2B);
        push_cmd(3'd0, 7'd10, 7'd5);
        send_frame(96'("+ 10 05"), 7, 0);
        idle(3);
        check("echo_stall_valid", int'(tx_valid), 1);
        tx_ready = 1'b1;
        idle(3);
        check("echo_stall_drained", exp_tx.size(), 0);
        check("echo_stall_valid_low", int'(tx_valid), 0);
        drained("echo_stall");
`endif

        check("final_cmd_queue", exp_cmd.size(), 0);
        check("final_err_queue", exp_err.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
